// File: rtl/fifo_rd_stream_adapter.sv
// Read-side responder for the async FIFO: drains a show-ahead FIFO into a
// two-entry skid buffer and presents it as a valid/ready stream with packet framing.
module fifo_rd_stream_adapter #(
    parameter int DSIZE   = 8,
    parameter int PKT_LEN = 4,
    parameter int CNT_W   = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    input  logic             en,
    output logic             out_valid,
    output logic [DSIZE-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic [1:0]       level,
    output logic [CNT_W-1:0] rd_count
);

    localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

    logic [1:0]       level_reg, level_next;
    logic [DSIZE-1:0] entry_reg  [2];
    logic [DSIZE-1:0] entry_next [2];
    logic [BW-1:0]    beat_reg, beat_next;
    logic [CNT_W-1:0] rd_count_reg, rd_count_next;

    logic       push;
    logic       pop;
    logic [1:0] wr_idx;

    // Popping is gated only by our own occupancy, never by out_ready, so the
    // FIFO read path stays free of any downstream combinational dependency.
    assign push   = rrst_n & en & ~rempty & (level_reg != 2'd2);
    assign pop    = (level_reg != 2'd0) & out_ready;
    assign wr_idx = level_reg - {1'b0, pop};
    assign rinc   = push;

    // A new word lands in the first slot left free after this cycle's pop.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            if (gi == 0) begin : g_head
                assign entry_next[gi] = (push && wr_idx == 2'(gi)) ? rdata :
                                        pop                        ? entry_reg[gi+1] :
                                                                     entry_reg[gi];
            end else begin : g_tail
                assign entry_next[gi] = (push && wr_idx == 2'(gi)) ? rdata : entry_reg[gi];
            end
        end
    endgenerate

    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + 2'd1;
            2'b01:   level_next = level_reg - 2'd1;
            default: level_next = level_reg;
        endcase
    end

    always_comb begin
        beat_next = beat_reg;
        if (pop) begin
            beat_next = (beat_reg == LAST_BEAT) ? '0 : beat_reg + BW'(1);
        end
    end

    assign rd_count_next = rd_count_reg + CNT_W'(push);

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            level_reg    <= 2'd0;
            beat_reg     <= '0;
            rd_count_reg <= '0;
            for (int i = 0; i < 2; i++) begin
                entry_reg[i] <= '0;
            end
        end else begin
            level_reg    <= level_next;
            beat_reg     <= beat_next;
            rd_count_reg <= rd_count_next;
            for (int i = 0; i < 2; i++) begin
                entry_reg[i] <= entry_next[i];
            end
        end
    end

    assign out_valid = (level_reg != 2'd0);
    assign out_data  = entry_reg[0];
    assign out_last  = out_valid & (beat_reg == LAST_BEAT);
    assign level     = level_reg;
    assign rd_count  = rd_count_reg;

endmodule
